// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT datapath types, constants and index helpers
package fft_pkg;

    localparam int FFT_N = 8;
    localparam int FFT_W = 16;
    localparam int LOG2N = $clog2(FFT_N);

    // One complex sample: index 0 = real, index 1 = imaginary.
    typedef logic signed [1:0][FFT_W-1:0] cplx_t;

    // Reverse the low log2n bits of idx; bits above log2n are ignored.
    function automatic int unsigned bitrev(input int unsigned idx, input int log2n);
        int unsigned r;
        r = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < log2n) begin
                r = (r << 1) | ((idx >> b) & 32'd1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_buffer.sv
// rtl/fft_bitrev_buffer.sv - ping-pong input buffer storing FFT frames in bit-reversed order
module fft_bitrev_buffer
    import fft_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_first,
    input  logic signed [W-1:0]                in_re,
    input  logic signed [W-1:0]                in_im,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [N-1:0][1:0][W-1:0]    out_frame,
    output logic                               sync_err
);

    localparam int AW = $clog2(N);

    logic signed [1:0][N-1:0][1:0][W-1:0] mem;
    logic          wb;
    logic          rb;
    logic [AW-1:0] widx;
    logic [1:0]    bank_full;
    logic [1:0]    full_next;
    logic [AW-1:0] waddr;
    logic          accept;
    logic          resync;
    logic          complete;
    logic          rd_release;

    assign in_ready   = !bank_full[wb];
    assign out_valid  = bank_full[rb];
    assign out_frame  = mem[rb];

    assign accept     = in_valid && in_ready;
    assign resync     = accept && in_first && (widx != '0);
    assign complete   = accept && !resync && (widx == AW'(N - 1));
    assign rd_release = out_valid && out_ready;

    // Write address: a resync restarts the frame at slot 0, otherwise bit-reverse the index.
    always_comb begin
        waddr = AW'(bitrev(32'(widx), AW));
        if (resync) begin
            waddr = '0;
        end
    end

    // Bank occupancy: release and completion always target different banks.
    always_comb begin
        full_next = bank_full;
        if (rd_release) begin
            full_next[rb] = 1'b0;
        end
        if (complete) begin
            full_next[wb] = 1'b1;
        end
    end

    // Control registers: bank pointers, write index, occupancy and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb        <= 1'b0;
            rb        <= 1'b0;
            widx      <= '0;
            bank_full <= '0;
            sync_err  <= 1'b0;
        end else begin
            bank_full <= full_next;
            sync_err  <= resync;
            if (rd_release) begin
                rb <= ~rb;
            end
            if (accept) begin
                if (resync) begin
                    widx <= AW'(1);
                end else if (complete) begin
                    widx <= '0;
                    wb   <= ~wb;
                end else begin
                    widx <= widx + 1'b1;
                end
            end
        end
    end

    // Sample storage: each accepted sample lands in the write bank at its bit-reversed slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (accept) begin
            mem[wb][waddr][0] <= in_re;
            mem[wb][waddr][1] <= in_im;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// tb/tb_fft_bitrev_buffer.sv - self-checking bench for fft_bitrev_buffer
module tb_fft_bitrev_buffer;

    localparam int N = 8;
    localparam int W = 16;

    typedef logic signed [N-1:0][1:0][W-1:0] frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_first = 1'b0;
    logic out_ready = 1'b0;
    logic signed [W-1:0] in_re = '0;
    logic signed [W-1:0] in_im = '0;
    logic in_ready;
    logic out_valid;
    logic sync_err;
    frame_t out_frame;

    logic in2_valid = 1'b0;
    logic in2_first = 1'b0;
    logic out2_ready = 1'b0;
    logic signed [7:0] in2_re = '0;
    logic signed [7:0] in2_im = '0;
    logic in2_ready;
    logic out2_valid;
    logic sync2_err;
    logic signed [1:0][1:0][7:0] out2_frame;

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;

    frame_t q[$];
    int     cur_re[N];
    int     cur_im[N];
    int     cnt = 0;
    bit     err_exp = 1'b0;
    bit     mon_on = 1'b0;
    int     err_seen = 0;
    int     valid_seen = 0;
    int     stall_seen = 0;

    int brv[N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft_bitrev_buffer #(.N(N), .W(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frame (out_frame),
        .sync_err  (sync_err)
    );

    fft_bitrev_buffer #(.N(2), .W(8)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in2_valid),
        .in_ready  (in2_ready),
        .in_first  (in2_first),
        .in_re     (in2_re),
        .in_im     (in2_im),
        .out_valid (out2_valid),
        .out_ready (out2_ready),
        .out_frame (out2_frame),
        .sync_err  (sync2_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    // Frame-level model: a queue of finished frames, in_ready while fewer than two are held.
    task automatic model_step();
        bit acc;
        bit rel;
        frame_t f;
        acc = in_valid && (q.size() < 2);
        rel = (q.size() > 0) && out_ready;
        err_exp = 1'b0;
        if (rel) begin
            void'(q.pop_front());
        end
        if (acc) begin
            if (in_first && cnt != 0) begin
                err_exp = 1'b1;
                cnt = 0;
            end
            cur_re[cnt] = int'(in_re);
            cur_im[cnt] = int'(in_im);
            cnt++;
            if (cnt == N) begin
                for (int p = 0; p < N; p++) begin
                    int s;
                    s = (p % 2) * 4 + ((p / 2) % 2) * 2 + p / 4;
                    f[p][0] = W'(cur_re[s]);
                    f[p][1] = W'(cur_im[s]);
                end
                q.push_back(f);
                cnt = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            cnt = 0;
            err_exp = 1'b0;
            check("rst_out_frame", out_frame, '0);
        end
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        check("sync_err", sync_err, err_exp);
        if (q.size() > 0) begin
            check("out_frame", out_frame, q[0]);
        end
        if (sync_err) err_seen++;
        if (mon_on && out_valid) valid_seen++;
        if (mon_on && !in_ready) stall_seen++;
        if (rst_n) model_step();
    end

    task automatic send(input int re, input int im, input bit first);
        bit took;
        int guard;
        in_valid = 1'b1;
        in_re = W'(re);
        in_im = W'(im);
        in_first = first;
        took = 1'b0;
        guard = 0;
        while (!took && guard < 100) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!took) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: actual not accepted required accepted re=%0d", re);
        end else begin
            n_acc++;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Frame in natural order, consumer always ready.
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) send(k, -k, k == 0);
        @(negedge clk);
        check_int("t1_valid", out_valid, 1);
        for (int i = 0; i < N; i++) begin
            check_int("t1_re", int'($signed(out_frame[i][0])), brv[i]);
            check_int("t1_im", int'($signed(out_frame[i][1])), -brv[i]);
        end
        @(posedge clk);
        #1;

        // Backpressure: both banks fill, then the consumer drains one at a time.
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                for (int k = 0; k < 24; k++) send(k, k, (k % 8) == 0);
            end
            begin
                guard = 0;
                do begin
                    @(negedge clk);
                    guard++;
                end while (in_ready && guard < 200);
                check_int("t2_acc_at_stall", n_acc - base, 16);
                check_int("t2_f0_re1", int'($signed(out_frame[1][0])), 4);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                check_int("t2_ready_back", in_ready, 1);
                check_int("t2_f1_re1", int'($signed(out_frame[1][0])), 12);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Resync mid-frame.
        err_seen = 0;
        send(1, 0, 1);
        send(2, 0, 0);
        send(3, 0, 0);
        send(100, -100, 1);
        for (int k = 101; k < 108; k++) send(k, -k, 0);
        @(negedge clk);
        check_int("t3_valid", out_valid, 1);
        check_int("t3_re1", int'($signed(out_frame[1][0])), 104);
        check_int("t3_re7", int'($signed(out_frame[7][0])), 107);
        repeat (2) @(posedge clk);
        #1;
        check_int("t3_err_pulses", err_seen, 1);

        // Reset in the middle of a frame.
        for (int k = 0; k < 5; k++) send(200 + k, 0, k == 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_int("t4_rst_valid", out_valid, 0);
        check_int("t4_rst_ready", in_ready, 1);
        check_int("t4_rst_err", sync_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_int("t4_post_valid", out_valid, 0);
        check_int("t4_post_err", sync_err, 0);
        @(posedge clk);
        #1;
        err_seen = 0;
        for (int k = 0; k < N; k++) send(300 + k, k, k == 0);
        @(negedge clk);
        check_int("t4_re4", int'($signed(out_frame[4][0])), 301);
        check_int("t4_no_err", err_seen, 0);
        @(posedge clk);
        #1;

        // Sustained streaming.
        valid_seen = 0;
        stall_seen = 0;
        mon_on = 1'b1;
        for (int k = 0; k < 64; k++) send(1000 + k, -(1000 + k), (k % 8) == 0);
        repeat (2) @(negedge clk);
        mon_on = 1'b0;
        check_int("t5_frames", valid_seen, 8);
        check_int("t5_stalls", stall_seen, 0);
        @(posedge clk);
        #1;

        // N=2, W=8 instance, bit-exact extremes.
        check_int("t6_ready", in2_ready, 1);
        in2_valid = 1'b1;
        in2_first = 1'b1;
        in2_re = 8'sd5;
        in2_im = -8'sd3;
        @(posedge clk);
        #1;
        in2_first = 1'b0;
        in2_re = -8'sd128;
        in2_im = 8'sd127;
        @(posedge clk);
        #1;
        in2_valid = 1'b0;
        @(negedge clk);
        check_int("t6_valid", out2_valid, 1);
        check_int("t6_re0", int'($signed(out2_frame[0][0])), 5);
        check_int("t6_im0", int'($signed(out2_frame[0][1])), -3);
        check_int("t6_re1", int'($signed(out2_frame[1][0])), -128);
        check_int("t6_im1", int'($signed(out2_frame[1][1])), 127);
        check_int("t6_err", sync2_err, 0);
        @(posedge clk);
        #1;
        out2_ready = 1'b1;
        @(posedge clk);
        #1;
        out2_ready = 1'b0;
        @(negedge clk);
        check_int("t6_drained", out2_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_buffer.md
Name: fft_bitrev_buffer

Overview:
- Input stage of the radix-2 FFT datapath; sits directly upstream of the first butterfly level.
- Accepts complex samples one per cycle in natural order over a valid/ready handshake.
- Stores each N-sample frame at bit-reversed addresses.
- Presents the completed frame as a parallel array [N][1:0] (index 0 = real, 1 = imag) to the butterfly tree.
- Ping-pong banks let the next frame fill while the current frame is held for the consumer.

Parameters:
- N, 8, FFT size in complex samples; power of two, N >= 2.
- W, 16, signed width of each real/imag component.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input sample present.
- in_ready  output  1  buffer can accept a sample this cycle.
- in_first  input  1  marks the current input sample as sample 0 of a frame.
- in_re  input  W  signed real part.
- in_im  input  W  signed imaginary part.
- out_valid  output  1  complete frame available.
- out_ready  input  1  consumer takes the frame this cycle.
- out_frame  output  [N][1:0] x W  signed frame in bit-reversed order.
- sync_err  output  1  one-cycle pulse: a partial frame was discarded.

Behaviour:
- Reset is asynchronous on rst_n low. While reset is held and after release:
  - wb = 0, rb = 0, widx = 0, bank_full[1:0] = 0.
  - in_ready = 1, out_valid = 0, sync_err = 0, out_frame = all zeros.
  - Both banks are cleared to 0.
- Storage: two banks, each N x 2 x W. wb is the write-bank pointer, rb the read-bank pointer, widx the write index (log2(N) bits).
- in_ready = !bank_full[wb] (combinational from registers). Input is accepted when in_valid && in_ready.
- On accept with in_first = 0 or widx = 0:
  - Write the sample to bank[wb][bitrev(widx)].
  - If widx == N-1: set bank_full[wb] = 1, toggle wb, set widx = 0.
  - Otherwise increment widx.
- On accept with in_first = 1 and widx != 0:
  - Discard the partial frame and pulse sync_err high for exactly one cycle.
  - Write the sample to bank[wb][0] and set widx = 1.
  - Stale entries are overwritten as the new frame fills.
- in_first = 1 with widx = 0 is normal operation; no error.
- in_first is ignored when the sample is not accepted.
- out_valid = bank_full[rb]; out_frame = bank[rb] (registered storage, no combinational path from inputs).
- On out_valid && out_ready: clear bank_full[rb] and toggle rb.
- Latency: the accept of the frame's last sample at edge t gives out_valid = 1 from edge t (visible in cycle t+1). The frame is available one cycle after the final accept.
- Throughput: sustained one frame per N cycles when out_ready is held at 1; in_ready never deasserts.
- Simultaneous frame completion on bank wb and release of bank rb in the same cycle: both take effect; they are always different banks.
- The write bank is never a full bank, because in_ready gates writes.
- Both banks full: in_ready = 0 and the input stalls. When out_ready releases rb, in_ready rises the next cycle.
- out_frame must remain stable while out_valid = 1 and out_ready = 0.
- bitrev(i): reverse the log2(N) bits of i. For N = 2 it is the identity.
- No arithmetic; data passes bit-exact at W bits.
- Reset mid-frame: partial data is lost, all flags clear, and no spurious out_valid or sync_err appears after release.

Decomposition:
- Shared package fft_pkg:
  - function bitrev(idx, log2n).
  - Constant LOG2N derived via $clog2(N).
  - typedef of the complex sample as a [1:0] array of signed [W-1:0].
- The butterfly stages reuse the same package.
- No sub-module is needed; the ping-pong bank is a single memory array inside this block.

Test Plan:
1. N=8, out_ready=1. Stream re=k, im=-k for k=0..7 with in_first at k=0.
   -> out_valid for one cycle, one cycle after the 8th accept.
   -> out_frame re order = 0,4,2,6,1,5,3,7; im order = 0,-4,-2,-6,-1,-5,-3,-7.
2. out_ready=0, stream 24 samples (re = 0..23).
   -> in_ready falls after the 16th accept; the 17th sample is held.
   -> Pulse out_ready: frame 0 (re 0..7, bit-reversed) is presented; in_ready rises the next cycle.
   -> Then frame 1 (re 8..15) is presented; the sample with re=16 is accepted and the stream resumes.
3. Accept 3 samples, then in_first=1 with re=100, followed by re=101..107.
   -> sync_err high for exactly one cycle.
   -> The output frame contains only 100..107 in bit-reversed order.
4. Assert rst_n=0 after 5 samples of a frame.
   -> out_valid=0, in_ready=1, sync_err=0 immediately and after release.
   -> The next full frame outputs correctly.
5. Continuous in_valid=1, out_ready=1 for 64 cycles.
   -> in_ready is constantly 1.
   -> out_valid pulses every 8 cycles with 8 correct consecutive frames.
6. N=2, W=8, input (5,-3) then (-128,127).
   -> out_frame[0] = (5,-3), out_frame[1] = (-128,127), bit-exact.
